// File: rtl/ocl_miner_host_master.sv
// ocl_miner_host_master: AXI-Lite master that loads a 640-bit block into the miner and polls for a nonce
module ocl_miner_host_master #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0504,
  parameter logic [31:0] RESULT_ADDR = 32'h0000_0554,
  parameter int          POLL_GAP    = 16,
  parameter logic [15:0] MAX_POLLS   = 16'd0
) (
  input  logic         clk_main_a0,
  input  logic         rst_main_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [639:0] blk_data,
  input  logic         abort,
  output logic         done_valid,
  output logic [1:0]   done_status,
  output logic [31:0]  done_nonce,
  output logic         busy,
  output logic         m_awvalid,
  output logic [31:0]  m_awaddr,
  input  logic         m_awready,
  output logic         m_wvalid,
  output logic [31:0]  m_wdata,
  output logic [3:0]   m_wstrb,
  input  logic         m_wready,
  input  logic         m_bvalid,
  input  logic [1:0]   m_bresp,
  output logic         m_bready,
  output logic         m_arvalid,
  output logic [31:0]  m_araddr,
  input  logic         m_arready,
  input  logic         m_rvalid,
  input  logic [31:0]  m_rdata,
  input  logic [1:0]   m_rresp,
  output logic         m_rready
);
  typedef enum logic [3:0] {IDLE, BASE_AR, BASE_R, WR_AW_W, WR_B, POLL_WAIT, POLL_AR, POLL_R, DONE} state_t;
  localparam int GW = $clog2(POLL_GAP + 1);
  state_t        state, state_n;
  logic [639:0]  blk;
  logic [4:0]    idx;
  logic [15:0]   polls;
  logic [GW-1:0] gap;
  logic [31:0]   baseline;
  logic          aw_done, w_done, fin;
  logic [1:0]    fin_status;
  logic [31:0]   fin_nonce;
  assign blk_ready  = state == IDLE;
  assign busy       = state != IDLE;
  assign done_valid = state == DONE;
  assign m_awvalid  = state == WR_AW_W && !aw_done;
  assign m_wvalid   = state == WR_AW_W && !w_done;
  assign m_awaddr   = m_awvalid ? BASE_ADDR + {25'd0, idx, 2'b00} : '0;
  assign m_wdata    = m_wvalid ? blk[639:608] : '0;
  assign m_wstrb    = 4'hF;
  assign m_bready   = state == WR_B;
  assign m_arvalid  = state == BASE_AR || state == POLL_AR;
  assign m_araddr   = m_arvalid ? RESULT_ADDR : '0;
  assign m_rready   = state == BASE_R || state == POLL_R;
  always_comb begin
    state_n    = state;
    fin        = 1'b0;
    fin_status = 2'd0;
    fin_nonce  = '0;
    case (state)
      IDLE:      state_n = blk_valid ? BASE_AR : IDLE;
      BASE_AR:   state_n = m_arready ? BASE_R : BASE_AR;
      BASE_R:    if (m_rvalid) begin
                   fin        = m_rresp != 2'd0;
                   fin_status = 2'd2;
                   state_n    = WR_AW_W;
                 end
      WR_AW_W:   state_n = (aw_done || m_awready) && (w_done || m_wready) ? WR_B : WR_AW_W;
      WR_B:      if (m_bvalid) begin
                   fin        = m_bresp != 2'd0;
                   fin_status = 2'd2;
                   state_n    = idx == 5'd19 ? POLL_WAIT : WR_AW_W;
                 end
      POLL_WAIT: begin
                   fin        = abort;
                   fin_status = 2'd3;
                   state_n    = gap == GW'(POLL_GAP - 1) ? POLL_AR : POLL_WAIT;
                 end
      POLL_AR:   state_n = m_arready ? POLL_R : POLL_AR;
      POLL_R:    if (m_rvalid) begin
                   fin        = m_rresp != 2'd0 || m_rdata != baseline || (MAX_POLLS != 16'd0 && polls == MAX_POLLS);
                   fin_status = m_rresp != 2'd0 ? 2'd2 : m_rdata != baseline ? 2'd0 : 2'd1;
                   fin_nonce  = m_rresp == 2'd0 && m_rdata != baseline ? m_rdata : '0;
                   state_n    = POLL_WAIT;
                 end
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
    state_n = fin ? DONE : state_n;
  end
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      state       <= IDLE;
      blk         <= '0;
      idx         <= '0;
      polls       <= '0;
      gap         <= '0;
      baseline    <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      done_status <= 2'd0;
      done_nonce  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && blk_valid) begin
        blk   <= blk_data;
        idx   <= '0;
        polls <= '0;
      end
      // the current word always sits in the top 32 bits; shift after each accepted write
      if (state == WR_B && state_n == WR_AW_W) begin
        blk <= blk << 32;
        idx <= idx + 5'd1;
      end
      aw_done <= state == WR_AW_W && (aw_done || m_awready);
      w_done  <= state == WR_AW_W && (w_done || m_wready);
      if (state == BASE_R && m_rvalid) baseline <= m_rdata;
      gap <= state == POLL_WAIT ? gap + 1'b1 : '0;
      if (state == POLL_AR && m_arready && polls != '1) polls <= polls + 16'd1;
      if (fin) begin
        done_status <= fin_status;
        done_nonce  <= fin_nonce;
      end
    end
  end
endmodule

// File: tb/tb_ocl_miner_host_master.sv
// tb_ocl_miner_host_master: directed and randomized runs against an AXI-Lite slave model and an outcome model
module tb_ocl_miner_host_master;
  localparam int GAP  = 3;
  localparam int MAXP = 4;
  logic         clk_main_a0 = 1'b0;
  logic         rst_main_n;
  logic         blk_valid, blk_ready, abort, done_valid, busy;
  logic [639:0] blk_data;
  logic [1:0]   done_status;
  logic [31:0]  done_nonce;
  logic         m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic         m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0]  m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]   m_wstrb;
  logic [1:0]   m_bresp, m_rresp;

  ocl_miner_host_master #(.POLL_GAP(GAP), .MAX_POLLS(16'(MAXP))) dut (
    .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .abort(abort),
    .done_valid(done_valid), .done_status(done_status), .done_nonce(done_nonce), .busy(busy),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready)
  );

  always #5 clk_main_a0 = ~clk_main_a0;

  int tests = 0, fails = 0;
  int stab_err = 0;
  logic [63:0] wr_q[$];
  logic [31:0] ar_q[$];
  bit          s_bp = 0;
  int          s_err = -1, s_fa = 0, s_ard = 0;
  logic [31:0] s_base = 0, s_nonce = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // AXI-Lite slave: acts on negedges, retiring the handshakes of the preceding posedge
  initial begin
    bit aw_got, w_got, pv_aw, pv_w, pv_b, pv_ar, pv_r;
    logic [31:0] aw_a, w_d, pa_aw, pa_w, pa_ar;
    int aw_wait, w_wait, ar_wait;
    forever begin
      @(negedge clk_main_a0);
      if (!rst_main_n) begin
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
        pv_aw = 0; pv_w = 0; pv_b = 0; pv_ar = 0; pv_r = 0;
      end else begin
        if (pv_aw && !m_awready && !(m_awvalid && m_awaddr == pa_aw)) stab_err++;
        if (pv_w && !m_wready && !(m_wvalid && m_wdata == pa_w)) stab_err++;
        if (pv_ar && !m_arready && !(m_arvalid && m_araddr == pa_ar)) stab_err++;
        if (m_wvalid && m_wstrb != 4'hF) stab_err++;
        if (m_arvalid && (m_awvalid || m_wvalid || m_bready)) stab_err++;
        if (pv_aw && m_awready) begin aw_got = 1; aw_a = pa_aw; end
        if (pv_w && m_wready) begin w_got = 1; w_d = pa_w; end
        if (pv_b && m_bvalid) m_bvalid = 0;
        if (pv_r && m_rvalid) m_rvalid = 0;
        if (pv_ar && m_arready) begin
          m_rvalid = 1;
          m_rdata = (s_fa != 0 && ar_q.size() >= s_fa) ? s_nonce : s_base;
          ar_q.push_back(pa_ar);
          ar_wait = 0;
        end
        if (aw_got && w_got) begin
          wr_q.push_back({aw_a, w_d});
          m_bvalid = 1;
          m_bresp = (wr_q.size() == s_err + 1) ? 2'b10 : 2'b00;
          aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0;
        end
        m_awready = m_awvalid && !aw_got && aw_wait >= ((s_bp && ((m_awaddr - 32'h504) & 32'h4) != 0) ? 2 : 0);
        if (m_awvalid && !aw_got && !m_awready) aw_wait++;
        m_wready = m_wvalid && !w_got && (!s_bp || (aw_got && w_wait >= 3));
        if (aw_got && !w_got) w_wait++;
        m_arready = m_arvalid && ar_wait >= s_ard;
        if (m_arvalid && !m_arready) ar_wait++;
        pv_aw = m_awvalid; pa_aw = m_awaddr; pv_w = m_wvalid; pa_w = m_wdata;
        pv_ar = m_arvalid; pa_ar = m_araddr; pv_b = m_bready; pv_r = m_rready;
      end
    end
  end

  function automatic logic [31:0] word(input logic [639:0] b, input int i);
    return b[639-32*i -: 32];
  endfunction

  task automatic run(input string nm, input logic [639:0] b, input logic [31:0] bs, input logic [31:0] nn,
                     input int fa, input int ew, input bit bp, input int ard, input bit abrt);
    int cyc, first_aw, e_st, e_wr, e_rd, bad;
    logic [31:0] e_nonce;
    bit timed;
    s_bp = bp; s_err = ew; s_fa = fa; s_ard = ard; s_base = bs; s_nonce = nn;
    wr_q.delete(); ar_q.delete(); stab_err = 0;
    // outcome model straight from the block's rules
    e_nonce = 0; e_wr = 20;
    if (ew >= 0 && ew < 20) begin e_st = 2; e_wr = ew + 1; e_rd = 1; end
    else if (abrt) begin e_st = 3; e_rd = 2; end
    else if (fa != 0 && (MAXP == 0 || fa <= MAXP)) begin e_st = 0; e_nonce = nn; e_rd = 1 + fa; end
    else begin e_st = 1; e_rd = 1 + MAXP; end
    timed = !bp && ard == 0 && !abrt && e_st < 2;
    @(negedge clk_main_a0);
    chk({nm, "_ready_idle"}, 64'(blk_ready), 64'd1);
    blk_data = b; blk_valid = 1;
    @(negedge clk_main_a0);
    blk_valid = 0; cyc = 1; first_aw = -1;
    chk({nm, "_ready_busy"}, 64'(blk_ready), 64'd0);
    while (!done_valid && cyc < 4000) begin
      if (m_awvalid && first_aw < 0) first_aw = cyc;
      if (abrt && m_arvalid && wr_q.size() == 20) abort = 1;
      @(negedge clk_main_a0);
      cyc++;
    end
    chk({nm, "_done_seen"}, 64'(done_valid), 64'd1);
    chk({nm, "_status"}, 64'(done_status), 64'(e_st));
    chk({nm, "_nonce"}, 64'(done_nonce), 64'(e_nonce));
    chk({nm, "_busy_in_done"}, 64'(busy), 64'd1);
    if (timed) begin
      chk({nm, "_first_aw_cyc"}, 64'(first_aw), 64'd3);
      chk({nm, "_done_cyc"}, 64'(cyc), 64'(43 + (e_rd - 1) * (GAP + 2)));
    end
    @(negedge clk_main_a0);
    abort = 0;
    chk({nm, "_done_pulse"}, 64'(done_valid), 64'd0);
    chk({nm, "_busy_after"}, 64'(busy), 64'd0);
    chk({nm, "_ready_after"}, 64'(blk_ready), 64'd1);
    chk({nm, "_nwrites"}, 64'(wr_q.size()), 64'(e_wr));
    for (int i = 0; i < wr_q.size() && i < e_wr; i++)
      chk($sformatf("%s_wr%0d", nm, i), wr_q[i], {32'h504 + 32'(4 * i), word(b, i)});
    chk({nm, "_nreads"}, 64'(ar_q.size()), 64'(e_rd));
    bad = 0;
    foreach (ar_q[i]) if (ar_q[i] != 32'h554) bad++;
    chk({nm, "_ar_addr"}, 64'(bad), 64'd0);
    chk({nm, "_axi_rules"}, 64'(stab_err), 64'd0);
  endtask

  initial begin
    logic [639:0] nb, rb;
    logic [31:0] bs, w12;
    int k;
    blk_valid = 0; blk_data = '0; abort = 0; rst_main_n = 0;
    for (int i = 0; i < 80; i++) nb[639-8*i -: 8] = 8'(i + 1);
    repeat (3) @(negedge clk_main_a0);
    chk("rst_ready", 64'(blk_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valids", 64'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, done_valid}), 64'd0);
    chk("rst_addrs", {m_awaddr, m_araddr}, 64'd0);
    chk("rst_wdata_nonce", {m_wdata, done_nonce}, 64'd0);
    chk("rst_status_strb", 64'({done_status, m_wstrb}), 64'h0F);
    rst_main_n = 1;
    run("nominal", nb, 32'h0, 32'hDEADBEEF, 3, -1, 0, 0, 0);
    for (int i = 0; i < 20; i++) rb[639-32*i -: 32] = $urandom;
    run("backpressure", rb, 32'h0BAD_F00D, 32'hCAFE_0001, 2, -1, 1, 0, 0);
    run("timeout", rb, 32'h12345678, 32'h0, 0, -1, 0, 0, 0);
    run("buserr", nb, 32'h0, 32'h1, 1, 7, 0, 0, 0);
    run("abort", rb, 32'h5, 32'h6, 0, -1, 0, 3, 1);
    // async reset in the middle of word 12's data phase
    s_bp = 0; s_err = -1; s_fa = 0; s_ard = 0; wr_q.delete(); ar_q.delete();
    w12 = word(nb, 12);
    @(negedge clk_main_a0);
    blk_data = nb; blk_valid = 1;
    @(negedge clk_main_a0);
    blk_valid = 0; k = 0;
    while (!(m_wvalid && m_wdata == w12) && k < 200) begin @(negedge clk_main_a0); k++; end
    chk("arst_reach_w12", 64'(m_wvalid && m_wdata == w12), 64'd1);
    #2 rst_main_n = 0;
    #1;
    chk("arst_valids", 64'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, done_valid}), 64'd0);
    chk("arst_ready", 64'({blk_ready, busy}), 64'b10);
    repeat (2) @(negedge clk_main_a0);
    rst_main_n = 1;
    run("after_rst", rb, 32'h7, 32'h8, 1, -1, 0, 0, 0);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 20; i++) rb[639-32*i -: 32] = $urandom;
      bs = $urandom;
      run($sformatf("rand%0d", r), rb, bs, bs ^ ($urandom | 32'h1), int'($urandom_range(0, 5)),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 19)) : -1, 1'($urandom_range(0, 1)), 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
